// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite accumulator slave: response codes,
// register offsets, channel FSM state types and the byte-strobe merge helper.
package axi_lite_pkg;

  localparam int unsigned AXI_DATA_W = 32;

  localparam logic [2:0] RESP_OKAY   = 3'd0;
  localparam logic [2:0] RESP_SLVERR = 3'd2;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_DATA   = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_RESULT = 8'h0C;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_HAVE_ADDR = 2'd1,
    W_HAVE_DATA = 2'd2,
    W_RESP      = 2'd3
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Byte lane i takes new_word only where strb[i] is set.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_lite_acc_slave_if.sv
// AXI4-Lite bus bundle between the address-decoding bus port and the
// accumulator slave.
interface axi_lite_acc_slave_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [RESP_WIDTH-1:0]   bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [RESP_WIDTH-1:0]   rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_acc_slave_core.sv
// Accumulator datapath: CTRL/DATA registers, wrapping ACC, write COUNT and
// sticky OVF. Strobes arrive already resolved (all ones when strobes are off).
module acc_slave_core
  import axi_lite_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctrl_we,
  input  logic        data_we,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] acc,
  output logic [15:0] count,
  output logic        ovf,
  output logic        acc_en
);

  logic [31:0] data_r;
  logic [31:0] acc_r;
  logic [15:0] count_r;
  logic        ovf_r;
  logic        acc_en_r;

  logic [31:0] data_merged_s;
  logic [1:0]  ctrl_bits_s;
  logic [32:0] sum_s;

  // CLR is never stored, so the CTRL lane falls back to {0, ACC_EN} when masked.
  always_comb begin
    data_merged_s = strb_merge(data_r, wdata, wstrb);
    ctrl_bits_s   = wstrb[0] ? wdata[1:0] : {1'b0, acc_en_r};
    sum_s         = {1'b0, acc_r} + {1'b0, data_merged_s};
  end

  // Register state: CTRL write (with optional clear) or DATA accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r   <= 32'd0;
      acc_r    <= 32'd0;
      count_r  <= 16'd0;
      ovf_r    <= 1'b0;
      acc_en_r <= 1'b0;
    end else if (ctrl_we) begin
      acc_en_r <= ctrl_bits_s[0];
      if (ctrl_bits_s[1]) begin
        acc_r   <= 32'd0;
        count_r <= 16'd0;
        ovf_r   <= 1'b0;
      end
    end else if (data_we) begin
      data_r <= data_merged_s;
      if (acc_en_r) begin
        acc_r   <= sum_s[31:0];
        count_r <= count_r + 16'd1;
        if (sum_s[32]) begin
          ovf_r <= 1'b1;
        end
      end
    end
  end

  assign acc    = acc_r;
  assign count  = count_r;
  assign ovf    = ovf_r;
  assign acc_en = acc_en_r;

endmodule

// File: rtl/axi_lite_acc_slave.sv
// AXI4-Lite accumulator slave top: write/read channel FSMs and address decode.
// Define AXI_ACC_SLAVE_STRB_EN to honour wstrb on CTRL/DATA writes.
module axi_lite_acc_slave
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int BASE_ADDR  = 0
) (
  input  logic                 s_axi_aclk,
  input  logic                 s_axi_aresetn,
  axi_lite_acc_slave_if.slave  s_axi
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] BASE_S = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [RESP_WIDTH-1:0] OKAY_S = RESP_WIDTH'(RESP_OKAY);
  localparam logic [RESP_WIDTH-1:0] SLVERR_S = RESP_WIDTH'(RESP_SLVERR);

  w_state_t              w_state_r;
  r_state_t              r_state_r;
  logic                  awready_r, wready_r, bvalid_r;
  logic [RESP_WIDTH-1:0] bresp_r;
  logic                  arready_r, rvalid_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [RESP_WIDTH-1:0] rresp_r;
  logic [ADDR_WIDTH-1:0] awaddr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
`ifdef AXI_ACC_SLAVE_STRB_EN
  logic [STRB_WIDTH-1:0] wstrb_r;
`endif

  logic                  aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s, wr_off_s, rd_off_s;
  logic [DATA_WIDTH-1:0] wr_data_s, rd_data_s;
  logic [STRB_WIDTH-1:0] wr_strb_s;
  logic                  wr_legal_s, ctrl_we_s, data_we_s;
  logic [RESP_WIDTH-1:0] wr_resp_s, rd_resp_s;

  logic [31:0] acc_s;
  logic [15:0] count_s;
  logic        ovf_s, acc_en_s;

  assign aw_hs_s = s_axi.awvalid & awready_r;
  assign w_hs_s  = s_axi.wvalid  & wready_r;
  assign ar_hs_s = s_axi.arvalid & arready_r;

  // The commit uses whichever half was captured earlier plus the half on the bus now.
  always_comb begin
    wr_addr_s = (w_state_r == W_HAVE_ADDR) ? awaddr_r : s_axi.awaddr;
    wr_data_s = (w_state_r == W_HAVE_DATA) ? wdata_r  : s_axi.wdata;
`ifdef AXI_ACC_SLAVE_STRB_EN
    wr_strb_s = (w_state_r == W_HAVE_DATA) ? wstrb_r  : s_axi.wstrb;
`else
    wr_strb_s = {STRB_WIDTH{1'b1}};
`endif
    case (w_state_r)
      W_IDLE:      commit_s = aw_hs_s & w_hs_s;
      W_HAVE_ADDR: commit_s = w_hs_s;
      W_HAVE_DATA: commit_s = aw_hs_s;
      default:     commit_s = 1'b0;
    endcase
    wr_off_s   = wr_addr_s - BASE_S;
    ctrl_we_s  = commit_s & (wr_off_s == ADDR_WIDTH'(OFF_CTRL));
    data_we_s  = commit_s & (wr_off_s == ADDR_WIDTH'(OFF_DATA));
    wr_legal_s = (wr_off_s == ADDR_WIDTH'(OFF_CTRL)) | (wr_off_s == ADDR_WIDTH'(OFF_DATA));
    wr_resp_s  = wr_legal_s ? OKAY_S : SLVERR_S;
  end

  // Read decode samples the pre-edge register values, so a same-cycle commit is not seen.
  always_comb begin
    rd_off_s = s_axi.araddr - BASE_S;
    case (rd_off_s)
      ADDR_WIDTH'(OFF_STATUS): begin
        rd_data_s = {{(DATA_WIDTH-18){1'b0}}, ovf_s, acc_en_s, count_s};
        rd_resp_s = OKAY_S;
      end
      ADDR_WIDTH'(OFF_RESULT): begin
        rd_data_s = acc_s;
        rd_resp_s = OKAY_S;
      end
      default: begin
        rd_data_s = {DATA_WIDTH{1'b0}};
        rd_resp_s = SLVERR_S;
      end
    endcase
  end

  // Write channel FSM; readies/bvalid are registered alongside the state.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= {RESP_WIDTH{1'b0}};
      awaddr_r  <= {ADDR_WIDTH{1'b0}};
      wdata_r   <= {DATA_WIDTH{1'b0}};
`ifdef AXI_ACC_SLAVE_STRB_EN
      wstrb_r   <= {STRB_WIDTH{1'b0}};
`endif
    end else begin
      case (w_state_r)
        W_IDLE, W_HAVE_ADDR, W_HAVE_DATA: begin
          if (commit_s) begin
            w_state_r <= W_RESP;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b1;
            bresp_r   <= wr_resp_s;
          end else if (w_state_r == W_IDLE && aw_hs_s) begin
            w_state_r <= W_HAVE_ADDR;
            awaddr_r  <= s_axi.awaddr;
            awready_r <= 1'b0;
            wready_r  <= 1'b1;
          end else if (w_state_r == W_IDLE && w_hs_s) begin
            w_state_r <= W_HAVE_DATA;
            wdata_r   <= s_axi.wdata;
`ifdef AXI_ACC_SLAVE_STRB_EN
            wstrb_r   <= s_axi.wstrb;
`endif
            awready_r <= 1'b1;
            wready_r  <= 1'b0;
          end else if (w_state_r == W_IDLE) begin
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            w_state_r <= W_IDLE;
            bvalid_r  <= 1'b0;
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
          end
        end
        default: begin
          w_state_r <= W_IDLE;
          awready_r <= 1'b0;
          wready_r  <= 1'b0;
          bvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read channel FSM; rdata/rresp captured at the AR handshake and held.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= {DATA_WIDTH{1'b0}};
      rresp_r   <= {RESP_WIDTH{1'b0}};
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (ar_hs_s) begin
            r_state_r <= R_DATA;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b1;
            rdata_r   <= rd_data_s;
            rresp_r   <= rd_resp_s;
          end else begin
            arready_r <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.rready) begin
            r_state_r <= R_IDLE;
            rvalid_r  <= 1'b0;
            arready_r <= 1'b1;
          end
        end
        default: begin
          r_state_r <= R_IDLE;
          arready_r <= 1'b0;
          rvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  acc_slave_core u_core (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .ctrl_we (ctrl_we_s),
    .data_we (data_we_s),
    .wdata   (wr_data_s[31:0]),
    .wstrb   (wr_strb_s[3:0]),
    .acc     (acc_s),
    .count   (count_s),
    .ovf     (ovf_s),
    .acc_en  (acc_en_s)
  );

  assign s_axi.awready = awready_r;
  assign s_axi.wready  = wready_r;
  assign s_axi.bvalid  = bvalid_r;
  assign s_axi.bresp   = bresp_r;
  assign s_axi.arready = arready_r;
  assign s_axi.rvalid  = rvalid_r;
  assign s_axi.rdata   = rdata_r;
  assign s_axi.rresp   = rresp_r;

endmodule

// File: tb/tb_axi_lite_acc_slave.sv
// Self-checking bench for axi_lite_acc_slave: directed protocol/timing steps
// plus random register traffic checked against a behavioural register model.
module tb_axi_lite_acc_slave;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  // Behavioural model of the visible register state.
  logic        m_en, m_ovf;
  logic [31:0] m_acc, m_data;
  int unsigned m_count;

  axi_lite_acc_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RESP_WIDTH(3)) bus ();

  axi_lite_acc_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3), .BASE_ADDR(0)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_en = 1'b0; m_ovf = 1'b0; m_acc = 32'd0; m_data = 32'd0; m_count = 0;
  endtask

  task automatic m_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic [2:0] r);
    logic [31:0] wd;
    longint unsigned sum;
    wd = (a == 8'h00) ? {31'd0, m_en} : m_data;
`ifdef AXI_ACC_SLAVE_STRB_EN
    for (int i = 0; i < 4; i++) if (s[i]) wd[8*i +: 8] = d[8*i +: 8];
`else
    wd = d;
`endif
    if (a == 8'h00) begin
      m_en = wd[0];
      if (wd[1]) begin m_acc = 32'd0; m_count = 0; m_ovf = 1'b0; end
      r = 3'd0;
    end else if (a == 8'h04) begin
      m_data = wd;
      if (m_en) begin
        sum = longint'(m_acc) + longint'(wd);
        if (sum > 64'h0000_0000_FFFF_FFFF) m_ovf = 1'b1;
        m_acc   = sum[31:0];
        m_count = (m_count + 1) % 65536;
      end
      r = 3'd0;
    end else begin
      r = 3'd2;
    end
  endtask

  function automatic logic [34:0] m_read(input logic [7:0] a);
    logic [15:0] c;
    c = m_count[15:0];
    if (a == 8'h08) return {3'd0, 14'd0, m_ovf, m_en, c};
    else if (a == 8'h0C) return {3'd0, m_acc};
    else return {3'd2, 32'd0};
  endfunction

  // Bus tasks start and end #1 after a rising edge.
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [2:0] resp);
    logic aw_done, w_done, awr, wr;
    int t;
    aw_done = 1'b0; w_done = 1'b0; t = 0;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    while (!(aw_done && w_done) && t < 50) begin
      awr = bus.awready; wr = bus.wready;
      @(posedge clk); #1; t++;
      if (awr && bus.awvalid) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
      if (wr && bus.wvalid) begin w_done = 1'b1; bus.wvalid = 1'b0; end
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("wr_addr_data_accepted", {30'd0, aw_done, w_done}, 32'd3);
    bus.bready = 1'b1; t = 0;
    while (!bus.bvalid && t < 50) begin @(posedge clk); #1; t++; end
    chk("wr_bvalid_seen", {31'd0, bus.bvalid}, 32'd1);
    resp = bus.bresp;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [2:0] resp);
    logic ar_done, arr;
    int t;
    ar_done = 1'b0; t = 0;
    bus.araddr = a; bus.arvalid = 1'b1;
    while (!ar_done && t < 50) begin
      arr = bus.arready;
      @(posedge clk); #1; t++;
      if (arr) begin ar_done = 1'b1; bus.arvalid = 1'b0; end
    end
    bus.arvalid = 1'b0;
    chk("rd_addr_accepted", {31'd0, ar_done}, 32'd1);
    bus.rready = 1'b1; t = 0;
    while (!bus.rvalid && t < 50) begin @(posedge clk); #1; t++; end
    chk("rd_rvalid_seen", {31'd0, bus.rvalid}, 32'd1);
    d = bus.rdata; resp = bus.rresp;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    logic [2:0] r, er;
    m_write(a, d, s, er);
    axi_write(a, d, s, r);
    chk(tag, {29'd0, r}, {29'd0, er});
  endtask

  task automatic do_read(input string tag, input logic [7:0] a);
    logic [31:0] d;
    logic [2:0]  r;
    logic [34:0] e;
    e = m_read(a);
    axi_read(a, d, r);
    chk({tag, "_data"}, d, e[31:0]);
    chk({tag, "_resp"}, {29'd0, r}, {29'd0, e[34:32]});
  endtask

  logic [7:0]  addrs [6] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h02};
  logic [2:0]  rr, er;
  logic [31:0] old, rd;
  logic [7:0]  ra;

  initial begin
    bus.awaddr = 8'd0; bus.awvalid = 1'b0; bus.wdata = 32'd0; bus.wstrb = 4'd0;
    bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = 8'd0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    m_reset();

    // Reset values, then readies rise on the first clock after release.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_handshake_outs", {27'd0, bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 32'd0);
    chk("rst_resps", {26'd0, bus.bresp, bus.rresp}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("readies_after_rst", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd7);

    do_read("rd_result_rst", 8'h0C);
    do_read("rd_status_rst", 8'h08);

    // Basic accumulate.
    do_write("wr_ctrl_en", 8'h00, 32'h1, 4'hF);
    do_write("wr_data5", 8'h04, 32'd5, 4'hF);
    do_write("wr_data7", 8'h04, 32'd7, 4'hF);
    axi_read(8'h0C, rd, rr);
    chk("result_12", rd, 32'd12);
    axi_read(8'h08, rd, rr);
    chk("status_cnt2", rd, 32'h0001_0002);

    // AW three cycles ahead of W.
    bus.awaddr = 8'h04; bus.awvalid = 1'b1;
    chk("split_awready_pre", {31'd0, bus.awready}, 32'd1);
    @(posedge clk); #1; bus.awvalid = 1'b0;
    chk("split_awready_low", {30'd0, bus.awready, bus.wready}, 32'd1);
    @(posedge clk); #1;
    chk("split_hold1", {30'd0, bus.awready, bus.bvalid}, 32'd0);
    @(posedge clk); #1;
    chk("split_hold2", {30'd0, bus.awready, bus.bvalid}, 32'd0);
    bus.wdata = 32'd3; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge clk); #1; bus.wvalid = 1'b0;
    m_write(8'h04, 32'd3, 4'hF, er);
    chk("split_bvalid_1cyc", {29'd0, bus.bvalid, bus.bresp[1:0]}, 32'd4);
    bus.bready = 1'b1; @(posedge clk); #1; bus.bready = 1'b0;
    chk("split_bvalid_drop", {31'd0, bus.bvalid}, 32'd0);
    do_read("split_result", 8'h0C);

    // Illegal offsets.
    axi_write(8'h10, 32'hDEAD_BEEF, 4'hF, rr);
    chk("bad_wr_bresp", {29'd0, rr}, 32'd2);
    axi_read(8'h00, rd, rr);
    chk("bad_rd_rresp", {29'd0, rr}, 32'd2);
    chk("bad_rd_rdata", rd, 32'd0);
    do_read("bad_after_result", 8'h0C);

    // B back-pressure with a second write pending.
    bus.awaddr = 8'h04; bus.wdata = 32'd100; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    m_write(8'h04, 32'd100, 4'hF, er);
    bus.wdata = 32'd1000;
    chk("bp_bvalid", {31'd0, bus.bvalid}, 32'd1);
    do_read("bp_mid_result", 8'h0C);
    for (int i = 0; i < 2; i++) begin
      chk("bp_hold", {29'd0, bus.bvalid, bus.awready, bus.wready}, 32'd4);
      @(posedge clk); #1;
    end
    bus.bready = 1'b1; @(posedge clk); #1; bus.bready = 1'b0;
    chk("bp_release", {29'd0, bus.bvalid, bus.awready, bus.wready}, 32'd3);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    m_write(8'h04, 32'd1000, 4'hF, er);
    chk("bp_second_bvalid", {31'd0, bus.bvalid}, 32'd1);
    bus.bready = 1'b1; @(posedge clk); #1; bus.bready = 1'b0;
    do_read("bp_final_result", 8'h0C);

    // Same-cycle commit and AR: read returns the pre-commit value.
    old = m_acc;
    bus.awaddr = 8'h04; bus.wdata = 32'h11; bus.wstrb = 4'hF; bus.araddr = 8'h0C;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    m_write(8'h04, 32'h11, 4'hF, er);
    chk("simul_valids", {30'd0, bus.bvalid, bus.rvalid}, 32'd3);
    chk("simul_pre_commit", bus.rdata, old);
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0; bus.rready = 1'b0;
    do_read("simul_post_commit", 8'h0C);

    // Carry out sets sticky OVF.
    do_write("ovf_clr", 8'h00, 32'h3, 4'hF);
    do_write("ovf_big", 8'h04, 32'hFFFF_FFFF, 4'hF);
    do_write("ovf_one", 8'h04, 32'h1, 4'hF);
    axi_read(8'h0C, rd, rr);
    chk("ovf_result0", rd, 32'd0);
    axi_read(8'h08, rd, rr);
    chk("ovf_status17", {31'd0, rd[17]}, 32'd1);
    do_read("ovf_status", 8'h08);
`ifdef AXI_ACC_SLAVE_STRB_EN
    do_write("strb_clr", 8'h00, 32'h3, 4'hF);
    do_write("strb_lane0", 8'h04, 32'hFFFF_FFFF, 4'h1);
    axi_read(8'h0C, rd, rr);
    chk("strb_result_ff", rd, 32'h0000_00FF);
    do_write("strb_none", 8'h04, 32'h1234_5678, 4'h0);
    do_read("strb_none_status", 8'h08);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 40; i++) begin
      ra = addrs[$urandom_range(0, 5)];
      if ($urandom_range(0, 1) == 0) begin
        do_write("rand_wr", ra, (ra == 8'h00) ? 32'($urandom_range(0, 3)) : 32'($urandom),
                 4'($urandom_range(0, 15)));
      end else begin
        do_read("rand_rd", ra);
      end
    end

    // Reset mid-transaction drops everything.
    bus.awaddr = 8'h04; bus.awvalid = 1'b1;
    @(posedge clk); #1; bus.awvalid = 1'b0;
    rst_n = 1'b0; #1;
    m_reset();
    chk("midrst_outs", {27'd0, bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 32'd0);
    chk("midrst_rdata", bus.rdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_read("midrst_result", 8'h0C);
    do_read("midrst_status", 8'h08);
    do_write("midrst_wr_ok", 8'h00, 32'h1, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_acc_slave.md
# axi_lite_acc_slave

AXI4-Lite slave peripheral that sits downstream of the two-port address-decoding bus and attaches to one of its master ports. It provides two write-only registers, CTRL and DATA, and two read-only registers, STATUS and RESULT. DATA writes feed a wrapping accumulator and a write counter. Write and read channels run independently, each with at most one outstanding transaction.

## Interface
- DATA_WIDTH, 32, data bus width; must be 32.
- ADDR_WIDTH, 8, address width.
- RESP_WIDTH, 3, response width.
- BASE_ADDR, 0, base address; 0 on the first bus port, 16 on the second.
- s_axi_aclk  in  1  sole clock; all logic on its rising edge.
- s_axi_aresetn  in  1  reset, asynchronous, active-low.
- s_axi_awaddr / s_axi_awvalid / s_axi_awready  in/in/out  ADDR_WIDTH/1/1  write address channel.
- s_axi_wdata / s_axi_wstrb / s_axi_wvalid / s_axi_wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- s_axi_bresp / s_axi_bvalid / s_axi_bready  out/out/in  RESP_WIDTH/1/1  write response channel.
- s_axi_araddr / s_axi_arvalid / s_axi_arready  in/in/out  ADDR_WIDTH/1/1  read address channel.
- s_axi_rdata / s_axi_rresp / s_axi_rvalid / s_axi_rready  out/out/out/in  DATA_WIDTH/RESP_WIDTH/1/1  read data channel.

## Operation
- Register map (offset from BASE_ADDR):
  - 0x0 CTRL (write-only): bit0 ACC_EN; bit1 CLR, self-clearing.
  - 0x4 DATA (write-only).
  - 0x8 STATUS (read-only): [15:0] COUNT, [16] ACC_EN, [17] OVF sticky, rest 0.
  - 0xC RESULT (read-only): ACC.
- Any other write offset, or any read offset other than 0x8/0xC:
  - response RESP_SLVERR (2), no state change, rdata 0.
- Legal accesses respond RESP_OKAY (0).
- CTRL write with CLR=1: ACC, COUNT and OVF go to 0 in the same cycle; ACC_EN takes the written bit0.
- DATA write: DATA register is updated. If ACC_EN=1:
  - ACC <= ACC + new DATA, modulo 2^32.
  - A carry out sets OVF.
  - COUNT increments, wrapping 0xFFFF -> 0.
- Write FSM states:
  - W_IDLE: awready=1, wready=1.
  - W_HAVE_ADDR: wready=1 only.
  - W_HAVE_DATA: awready=1 only.
  - W_RESP: bvalid=1, no readies.
- Write FSM transitions:
  - AW and W handshake in the same cycle in W_IDLE -> commit, go to W_RESP.
  - AW alone -> W_HAVE_ADDR; W alone -> W_HAVE_DATA.
  - The completing handshake -> commit, go to W_RESP.
  - W_RESP with bready=1 -> W_IDLE.
- Read FSM states:
  - R_IDLE: arready=1.
  - R_DATA: rvalid=1; rdata/rresp are registered at the AR handshake and held stable.
- Read FSM transitions: AR handshake -> R_DATA; R_DATA with rready=1 -> R_IDLE.
- Simultaneous write commit and AR handshake in the same cycle: the read returns the pre-commit value.
- Reset asserted mid-transaction: all state drops immediately and the transaction is lost. Reset values:
  - awready, wready, arready, bvalid, rvalid = 0.
  - bresp, rresp, rdata = 0.
  - CTRL, DATA, ACC, COUNT, OVF = 0.
- The readies rise on the first clock after reset deasserts.

## Timing
- Write latency: bvalid is asserted on the cycle after the later of the AW and W handshakes.
- Read latency: rvalid is asserted on the cycle after the AR handshake.
- The register update is visible to a read address accepted on the cycle after the commit.
- bvalid/bresp and rvalid/rdata/rresp are held until their ready; they never drop without a handshake.
- No new AW/W is accepted while in W_RESP; no new AR is accepted while in R_DATA.
- Peak throughput is one transaction per 2 cycles per channel.
- awaddr/araddr are captured at the handshake and need not remain stable afterwards.

## Configuration
- AXI_ACC_SLAVE_STRB_EN defined:
  - Byte lane i of CTRL/DATA is written only when wstrb[i]=1.
  - The accumulator adds the merged DATA value.
  - wstrb=0 still completes with OKAY and, if ACC_EN=1, increments COUNT.
- AXI_ACC_SLAVE_STRB_EN undefined: wstrb is ignored and full words are written.

## Structure
- Shared package axi_lite_pkg:
  - RESP_OKAY and RESP_SLVERR constants.
  - Register offset localparams.
  - Write and read FSM state typedefs.
- Sub-module acc_slave_core: ACC/COUNT/OVF datapath with commit, clear and strobe-merge inputs. The top level holds both channel FSMs and the address decode.

## Test plan
- Reset, then read 0xC -> rdata 0x0000_0000, rresp 0; read 0x8 -> 0x0000_0000.
- Write CTRL=0x1, then DATA=5, then DATA=7 -> read 0xC = 12, read 0x8 = 0x0001_0002.
- AW for 0x4 issued 3 cycles before W -> awready low from the cycle after the AW handshake; bvalid high exactly 1 cycle after the W handshake.
- Write 0x10, then read 0x0 -> bresp 2 and rresp 2 with rdata 0; a following read of 0xC is unchanged.
- Hold bready low 5 cycles with a second AW/W pending -> bvalid held, awready/wready stay 0, second write committed only after the first B handshake.
- ACC_EN=1, DATA=0xFFFF_FFFF then DATA=1 -> RESULT 0, STATUS[17]=1. With the macro defined, DATA=0xFFFF_FFFF with wstrb=0x1 from ACC=0 -> RESULT 0xFF.
